// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - accumulator ALU with flags, shadow register and multi-cycle MUL/DIV
//
// Purpose: accumulator/temp/shadow-register ALU for the CPU datapath. Single-cycle
// ops (0-17) complete on the start edge; MUL and DIV iterate WIDTH cycles under a
// start/busy/done handshake. All state updates on posedge clk; rst is asynchronous.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   op, start            operation select and one-cycle execute request
//   data_in              write data for acc, tmp and flags
//   acc_we, tmp_we       direct register loads
//   flags_we             load flags from data_in[4:0]
//   act_store/restore    copy acc to shadow act / act back to acc
//   busy, done           multi-cycle in progress / completion pulse
//   div_by_zero          sticky DIV-by-zero indicator, cleared on next start
//   flags_out            {AC,S,P,C,Z}
//   acc_out, ext_out     accumulator / MUL high half or DIV remainder
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   op,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             acc_we,
  input  logic             tmp_we,
  input  logic             flags_we,
  input  logic             act_store,
  input  logic             act_restore,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [4:0]       flags_out,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] ext_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_ADC = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_SBB = OPW'(3);
  localparam logic [OPW-1:0] OP_ANA = OPW'(4);
  localparam logic [OPW-1:0] OP_XRA = OPW'(5);
  localparam logic [OPW-1:0] OP_ORA = OPW'(6);
  localparam logic [OPW-1:0] OP_CMP = OPW'(7);
  localparam logic [OPW-1:0] OP_RLC = OPW'(8);
  localparam logic [OPW-1:0] OP_RRC = OPW'(9);
  localparam logic [OPW-1:0] OP_RAL = OPW'(10);
  localparam logic [OPW-1:0] OP_RAR = OPW'(11);
  localparam logic [OPW-1:0] OP_DAA = OPW'(12);
  localparam logic [OPW-1:0] OP_CMA = OPW'(13);
  localparam logic [OPW-1:0] OP_STC = OPW'(14);
  localparam logic [OPW-1:0] OP_CMC = OPW'(15);
  localparam logic [OPW-1:0] OP_INR = OPW'(16);
  localparam logic [OPW-1:0] OP_DCR = OPW'(17);
  localparam logic [OPW-1:0] OP_MUL = OPW'(18);
  localparam logic [OPW-1:0] OP_DIV = OPW'(19);

  localparam int F_Z  = 0;
  localparam int F_C  = 1;
  localparam int F_AC = 4;

  localparam logic [4:0] M_ALL  = 5'b11111;
  localparam logic [4:0] M_C    = 5'b00010;
  localparam logic [4:0] M_NOTC = 5'b11101;

  logic [WIDTH-1:0] acc_q, tmp_q, act_q, ext_q;
  logic [4:0]       flags_q;
  logic             busy_q, done_q, dbz_q;

  // Iteration state: work_hi/work_lo hold {partial product, multiplier} for MUL
  // and {partial remainder, dividend/quotient} for DIV.
  logic [WIDTH-1:0] work_hi, work_lo, opnd;
  logic             is_div;
  logic [CW-1:0]    cnt;

  assign acc_out     = acc_q;
  assign ext_out     = ext_q;
  assign flags_out   = flags_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

  function automatic logic [4:0] mk_flags(input logic ac, input logic c, input logic [WIDTH-1:0] r);
    mk_flags = {ac, r[WIDTH-1], ~^r[7:0], c, (r == '0)};
  endfunction

  logic             use_c;
  logic [WIDTH:0]   add_r, sub_r;
  logic [4:0]       add_l, sub_l, lo_daa;
  logic             lo_adj, hi_adj;
  logic [8:0]       daa_1;
  logic [9:0]       daa_2;
  logic [WIDTH-1:0] op_res;
  logic [4:0]       op_flags, op_mask, flags_base;
  logic             op_wr_acc, op_multi, op_div0;

  always_comb begin
    use_c  = (op == OP_ADC || op == OP_SBB) ? flags_q[F_C] : 1'b0;
    add_r  = {1'b0, acc_q} + {1'b0, tmp_q} + {{WIDTH{1'b0}}, use_c};
    add_l  = {1'b0, acc_q[3:0]} + {1'b0, tmp_q[3:0]} + {4'b0000, use_c};
    sub_r  = {1'b0, acc_q} - {1'b0, tmp_q} - {{WIDTH{1'b0}}, use_c};
    sub_l  = {1'b0, acc_q[3:0]} - {1'b0, tmp_q[3:0]} - {4'b0000, use_c};

    // BCD adjust: the high-nibble test looks at the low-adjusted value, so a
    // carry out of the first step also forces the +0x60 correction.
    lo_adj = (acc_q[3:0] > 4'd9) || flags_q[F_AC];
    lo_daa = {1'b0, acc_q[3:0]} + (lo_adj ? 5'd6 : 5'd0);
    daa_1  = {1'b0, acc_q[7:0]} + (lo_adj ? 9'd6 : 9'd0);
    hi_adj = (daa_1[8:4] > 5'd9) || flags_q[F_C];
    daa_2  = {1'b0, daa_1} + (hi_adj ? 10'h060 : 10'h000);

    flags_base = flags_we ? data_in[4:0] : flags_q;

    op_res    = acc_q;
    op_flags  = '0;
    op_mask   = '0;
    op_wr_acc = 1'b0;
    op_multi  = 1'b0;
    op_div0   = 1'b0;

    if (start && !busy_q) begin
      case (op)
        OP_ADD, OP_ADC: begin
          op_res = add_r[WIDTH-1:0]; op_wr_acc = 1'b1; op_mask = M_ALL;
          op_flags = mk_flags(add_l[4], add_r[WIDTH], add_r[WIDTH-1:0]);
        end
        OP_SUB, OP_SBB: begin
          op_res = sub_r[WIDTH-1:0]; op_wr_acc = 1'b1; op_mask = M_ALL;
          op_flags = mk_flags(sub_l[4], sub_r[WIDTH], sub_r[WIDTH-1:0]);
        end
        OP_CMP: begin
          op_mask = M_ALL;
          op_flags = mk_flags(sub_l[4], sub_r[WIDTH], sub_r[WIDTH-1:0]);
        end
        OP_ANA: begin
          op_res = acc_q & tmp_q; op_wr_acc = 1'b1; op_mask = M_ALL;
          op_flags = mk_flags(1'b1, 1'b0, acc_q & tmp_q);
        end
        OP_XRA: begin
          op_res = acc_q ^ tmp_q; op_wr_acc = 1'b1; op_mask = M_ALL;
          op_flags = mk_flags(1'b0, 1'b0, acc_q ^ tmp_q);
        end
        OP_ORA: begin
          op_res = acc_q | tmp_q; op_wr_acc = 1'b1; op_mask = M_ALL;
          op_flags = mk_flags(1'b0, 1'b0, acc_q | tmp_q);
        end
        OP_RLC: begin
          op_res = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]}; op_wr_acc = 1'b1;
          op_mask = M_C; op_flags[F_C] = acc_q[WIDTH-1];
        end
        OP_RRC: begin
          op_res = {acc_q[0], acc_q[WIDTH-1:1]}; op_wr_acc = 1'b1;
          op_mask = M_C; op_flags[F_C] = acc_q[0];
        end
        OP_RAL: begin
          op_res = {acc_q[WIDTH-2:0], flags_q[F_C]}; op_wr_acc = 1'b1;
          op_mask = M_C; op_flags[F_C] = acc_q[WIDTH-1];
        end
        OP_RAR: begin
          op_res = {flags_q[F_C], acc_q[WIDTH-1:1]}; op_wr_acc = 1'b1;
          op_mask = M_C; op_flags[F_C] = acc_q[0];
        end
        OP_DAA: begin
          op_res[7:0] = daa_2[7:0]; op_wr_acc = 1'b1; op_mask = M_ALL;
          op_flags = mk_flags(lo_daa[4], flags_q[F_C] | (daa_2[9:8] != 2'b00), op_res);
        end
        OP_CMA: begin
          op_res = ~acc_q; op_wr_acc = 1'b1;
        end
        OP_STC: begin
          op_mask = M_C; op_flags[F_C] = 1'b1;
        end
        OP_CMC: begin
          op_mask = M_C; op_flags[F_C] = ~flags_q[F_C];
        end
        OP_INR: begin
          op_res = acc_q + WIDTH'(1); op_wr_acc = 1'b1; op_mask = M_NOTC;
          op_flags = mk_flags(acc_q[3:0] == 4'hF, 1'b0, acc_q + WIDTH'(1));
        end
        OP_DCR: begin
          op_res = acc_q - WIDTH'(1); op_wr_acc = 1'b1; op_mask = M_NOTC;
          op_flags = mk_flags(acc_q[3:0] == 4'h0, 1'b0, acc_q - WIDTH'(1));
        end
        OP_MUL: op_multi = 1'b1;
        OP_DIV: begin
          if (tmp_q == '0) begin
            op_div0 = 1'b1; op_mask = M_C; op_flags[F_C] = 1'b1;
          end else begin
            op_multi = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [4:0]       fin_flags;

  always_comb begin
    mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_sh   = {work_hi, work_lo[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd};
    if (is_div) begin
      // Restoring step: keep the trial difference only when it did not go negative.
      if (!div_diff[WIDTH+1]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
      fin_flags = mk_flags(1'b0, 1'b0, step_lo);
    end else begin
      step_hi   = mul_sum[WIDTH:1];
      step_lo   = {mul_sum[0], work_lo[WIDTH-1:1]};
      fin_flags = mk_flags(1'b0, step_hi != '0, step_lo);
      fin_flags[F_Z] = (step_hi == '0) && (step_lo == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      tmp_q   <= '0;
      act_q   <= '0;
      ext_q   <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      work_hi <= '0;
      work_lo <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      cnt     <= '0;
    end else if (busy_q) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
      done_q  <= 1'b0;
      if (cnt == CW'(WIDTH-1)) begin
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        acc_q   <= step_lo;
        ext_q   <= step_hi;
        flags_q <= fin_flags;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      done_q <= start && !op_multi;
      if (start) dbz_q <= op_div0;

      if (op_wr_acc)        acc_q <= op_res;
      else if (acc_we)      acc_q <= data_in;
      else if (act_restore) acc_q <= act_q;

      flags_q <= (op_flags & op_mask) | (flags_base & ~op_mask);

      if (tmp_we)    tmp_q <= data_in;
      if (act_store) act_q <= acc_q;

      // Operands are latched here so direct loads on the start edge cannot disturb them.
      if (op_multi) begin
        busy_q  <= 1'b1;
        cnt     <= '0;
        work_hi <= '0;
        is_div  <= (op == OP_DIV);
        work_lo <= (op == OP_DIV) ? acc_q : tmp_q;
        opnd    <= (op == OP_DIV) ? tmp_q : acc_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] op;
  logic       start, acc_we, tmp_we, flags_we, act_store, act_restore;
  logic [7:0] din;
  logic       busy, done, dbz;
  logic [4:0] flags;
  logic [7:0] acc, ext;

  logic [4:0]  w_op;
  logic        w_start, w_acc_we, w_tmp_we, w_flags_we, w_act_store, w_act_restore;
  logic [15:0] w_din;
  logic        w_busy, w_done, w_dbz;
  logic [4:0]  w_flags;
  logic [15:0] w_acc, w_ext;

  alu_seq #(.WIDTH(8), .OPW(5)) u8 (
    .clk(clk), .rst(rst), .op(op), .start(start), .data_in(din),
    .acc_we(acc_we), .tmp_we(tmp_we), .flags_we(flags_we),
    .act_store(act_store), .act_restore(act_restore),
    .busy(busy), .done(done), .div_by_zero(dbz), .flags_out(flags),
    .acc_out(acc), .ext_out(ext));

  alu_seq #(.WIDTH(16), .OPW(5)) u16 (
    .clk(clk), .rst(rst), .op(w_op), .start(w_start), .data_in(w_din),
    .acc_we(w_acc_we), .tmp_we(w_tmp_we), .flags_we(w_flags_we),
    .act_store(w_act_store), .act_restore(w_act_restore),
    .busy(w_busy), .done(w_done), .div_by_zero(w_dbz), .flags_out(w_flags),
    .acc_out(w_acc), .ext_out(w_ext));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear8();
    start = 1'b0; acc_we = 1'b0; tmp_we = 1'b0; flags_we = 1'b0;
    act_store = 1'b0; act_restore = 1'b0;
  endtask

  // Reference model state (8-bit instance)
  int         m_acc, m_tmp, m_act, m_ext, m_opa, m_opb;
  logic [4:0] m_fl;
  bit         m_dbz, m_div;

  function automatic logic [4:0] fl(input bit ac, input bit c, input int v);
    logic [7:0] b;
    b = v[7:0];
    return {ac, b[7], ($countones(b) % 2 == 0), c, (b == 8'h00)};
  endfunction

  task automatic load8(input logic [7:0] a, input logic [7:0] t, input logic [4:0] f);
    din = a; acc_we = 1'b1; step(); acc_we = 1'b0;
    din = t; tmp_we = 1'b1; step(); tmp_we = 1'b0;
    din = {3'b000, f}; flags_we = 1'b1; step(); flags_we = 1'b0;
    din = 8'h00;
    m_acc = a; m_tmp = t; m_fl = f;
  endtask

  task automatic model_idle(input int o, input bit st, input int d, input bit awe, input bit twe,
                            input bit fwe, input bit ast, input bit ars,
                            output bit multi, output bit pulse);
    int a, t, r, v, cin, lo_add, pre_act;
    bit c, wr;
    logic [4:0] nf;
    a = m_acc; t = m_tmp; c = m_fl[1]; pre_act = m_act;
    nf = fwe ? d[4:0] : m_fl;
    wr = 1'b0; multi = 1'b0; r = a;
    if (st) begin
      m_dbz = 1'b0;
      case (o)
        0, 1: begin
          cin = (o == 1 && c) ? 1 : 0; v = a + t + cin; r = v & 255; wr = 1'b1;
          nf = fl(((a & 15) + (t & 15) + cin) > 15, v > 255, r);
        end
        2, 3, 7: begin
          cin = (o == 3 && c) ? 1 : 0; v = a - t - cin; r = v & 255; wr = (o != 7);
          nf = fl(((a & 15) - (t & 15) - cin) < 0, v < 0, r);
        end
        4: begin r = a & t; wr = 1'b1; nf = fl(1'b1, 1'b0, r); end
        5: begin r = a ^ t; wr = 1'b1; nf = fl(1'b0, 1'b0, r); end
        6: begin r = a | t; wr = 1'b1; nf = fl(1'b0, 1'b0, r); end
        8:  begin r = ((a * 2) + (a / 128)) % 256; wr = 1'b1; nf[1] = a[7]; end
        9:  begin r = (a / 2) + (a % 2) * 128; wr = 1'b1; nf[1] = a[0]; end
        10: begin r = ((a * 2) % 256) + (c ? 1 : 0); wr = 1'b1; nf[1] = a[7]; end
        11: begin r = (a / 2) + (c ? 128 : 0); wr = 1'b1; nf[1] = a[0]; end
        12: begin
          lo_add = ((a % 16) > 9 || m_fl[4]) ? 6 : 0;
          v = a + lo_add;
          if ((v / 16) > 9 || c) v = v + 96;
          r = v % 256; wr = 1'b1;
          nf = fl(((a % 16) + lo_add) > 15, c || v > 255, r);
        end
        13: begin r = 255 - a; wr = 1'b1; end
        14: nf[1] = 1'b1;
        15: nf[1] = ~c;
        16: begin r = (a + 1) % 256; wr = 1'b1; nf = fl((a % 16) == 15, nf[1], r); end
        17: begin r = (a + 255) % 256; wr = 1'b1; nf = fl((a % 16) == 0, nf[1], r); end
        18: begin multi = 1'b1; m_div = 1'b0; end
        19: begin
          if (t == 0) begin nf[1] = 1'b1; m_dbz = 1'b1; end
          else begin multi = 1'b1; m_div = 1'b1; end
        end
        default: ;
      endcase
    end
    m_opa = a; m_opb = t;
    if (wr) m_acc = r;
    else if (awe) m_acc = d & 255;
    else if (ars) m_acc = pre_act;
    if (ast) m_act = a;
    if (twe) m_tmp = d & 255;
    m_fl = nf;
    pulse = st && !multi;
  endtask

  task automatic model_finish();
    int p, q;
    if (m_div) begin
      q = m_opa / m_opb;
      m_acc = q; m_ext = m_opa % m_opb;
      m_fl = fl(1'b0, 1'b0, q);
    end else begin
      p = m_opa * m_opb;
      m_acc = p % 256; m_ext = p / 256;
      m_fl = fl(1'b0, m_ext != 0, m_acc);
      m_fl[0] = (p == 0);
    end
  endtask

  typedef struct {
    logic [4:0] o;
    logic [7:0] a, t;
    logic [4:0] f;
    logic [7:0] ea;
    logic [4:0] ef;
  } vec_t;

  vec_t tbl [19];

  initial begin
    bit   multi, pulse, st, awe, twe, fwe, ast, ars, got_done, saw_done, saw_busy;
    int   o, d, edge_n, nbusy;

    tbl[0]  = '{5'd0,  8'h3A, 8'hC6, 5'h00, 8'h00, 5'h17};
    tbl[1]  = '{5'd7,  8'h05, 8'h07, 5'h00, 8'h05, 5'h1A};
    tbl[2]  = '{5'd3,  8'h05, 8'h07, 5'h02, 8'hFD, 5'h1A};
    tbl[3]  = '{5'd8,  8'h81, 8'h00, 5'h00, 8'h03, 5'h02};
    tbl[4]  = '{5'd11, 8'h03, 8'h00, 5'h02, 8'h81, 5'h02};
    tbl[5]  = '{5'd12, 8'h9B, 8'h00, 5'h00, 8'h01, 5'h12};
    tbl[6]  = '{5'd4,  8'hF0, 8'h0F, 5'h1F, 8'h00, 5'h15};
    tbl[7]  = '{5'd5,  8'h55, 8'hFF, 5'h00, 8'hAA, 5'h0C};
    tbl[8]  = '{5'd13, 8'h5A, 8'h00, 5'h1F, 8'hA5, 5'h1F};
    tbl[9]  = '{5'd16, 8'hFF, 8'h00, 5'h02, 8'h00, 5'h17};
    tbl[10] = '{5'd17, 8'h00, 8'h00, 5'h00, 8'hFF, 5'h1C};
    tbl[11] = '{5'd14, 8'h12, 8'h00, 5'h00, 8'h12, 5'h02};
    tbl[12] = '{5'd15, 8'h12, 8'h00, 5'h1F, 8'h12, 5'h1D};
    tbl[13] = '{5'd25, 8'h12, 8'h00, 5'h09, 8'h12, 5'h09};
    tbl[14] = '{5'd1,  8'h0F, 8'h01, 5'h02, 8'h11, 5'h14};
    tbl[15] = '{5'd6,  8'h00, 8'h00, 5'h1F, 8'h00, 5'h05};
    tbl[16] = '{5'd9,  8'h01, 8'h00, 5'h00, 8'h80, 5'h02};
    tbl[17] = '{5'd10, 8'h80, 8'h00, 5'h00, 8'h00, 5'h02};
    tbl[18] = '{5'd2,  8'h10, 8'h01, 5'h00, 8'h0F, 5'h14};

    rst = 1'b1; op = 5'd0; din = 8'h00; clear8();
    w_op = 5'd0; w_start = 1'b0; w_din = 16'h0000; w_acc_we = 1'b0; w_tmp_we = 1'b0;
    w_flags_we = 1'b0; w_act_store = 1'b0; w_act_restore = 1'b0;
    step(); step();
    chk("reset acc", acc, 0);
    chk("reset ext", ext, 0);
    chk("reset flags", flags, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", dbz, 0);
    chk("reset w_acc", w_acc, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 19; i++) begin
      load8(tbl[i].a, tbl[i].t, tbl[i].f);
      op = tbl[i].o; start = 1'b1; step(); start = 1'b0;
      chk($sformatf("tbl%0d acc", i), acc, tbl[i].ea);
      chk($sformatf("tbl%0d flags", i), flags, tbl[i].ef);
      chk($sformatf("tbl%0d done", i), done, 1);
      step();
      chk($sformatf("tbl%0d done drop", i), done, 0);
    end

    // Randomised run against the model
    m_act = 0; m_ext = 0; m_dbz = 1'b0; m_div = 1'b0;
    load8(8'h5C, 8'h13, 5'h00);
    for (int n = 0; n < 400; n++) begin
      o   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 19));
      st  = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      awe = ($urandom_range(0, 3) == 0);
      twe = ($urandom_range(0, 3) == 0);
      fwe = ($urandom_range(0, 3) == 0);
      ast = ($urandom_range(0, 3) == 0);
      ars = ($urandom_range(0, 3) == 0);
      op = o[4:0]; start = st; din = d[7:0]; acc_we = awe; tmp_we = twe;
      flags_we = fwe; act_store = ast; act_restore = ars;
      model_idle(o, st, d, awe, twe, fwe, ast, ars, multi, pulse);
      step(); clear8();
      chk($sformatf("rnd%0d op%0d acc", n, o), acc, m_acc);
      chk($sformatf("rnd%0d op%0d flags", n, o), flags, m_fl);
      chk($sformatf("rnd%0d op%0d done", n, o), done, pulse);
      chk($sformatf("rnd%0d op%0d busy", n, o), busy, multi);
      chk($sformatf("rnd%0d op%0d dbz", n, o), dbz, m_dbz);
      chk($sformatf("rnd%0d op%0d ext", n, o), ext, m_ext);
      if (multi) begin
        for (int k = 0; k < 8; k++) begin
          op = 5'($urandom_range(0, 31)); din = 8'($urandom_range(0, 255));
          start = ($urandom_range(0, 1) == 1); acc_we = ($urandom_range(0, 1) == 1);
          tmp_we = ($urandom_range(0, 1) == 1); flags_we = ($urandom_range(0, 1) == 1);
          act_store = ($urandom_range(0, 1) == 1); act_restore = ($urandom_range(0, 1) == 1);
          step(); clear8();
          if (k == 7) model_finish();
          chk($sformatf("rnd%0d it%0d acc", n, k), acc, m_acc);
          chk($sformatf("rnd%0d it%0d ext", n, k), ext, m_ext);
          chk($sformatf("rnd%0d it%0d flags", n, k), flags, m_fl);
          chk($sformatf("rnd%0d it%0d busy", n, k), busy, (k != 7));
          chk($sformatf("rnd%0d it%0d done", n, k), done, (k == 7));
        end
      end
    end

    // MUL 0xFF*0xFF with start pulses while busy
    load8(8'hFF, 8'hFF, 5'h00);
    op = 5'd18; start = 1'b1; step(); start = 1'b0;
    edge_n = 1; nbusy = busy ? 1 : 0; got_done = 1'b0;
    while (!got_done && edge_n < 30) begin
      op = 5'd0; start = edge_n[0];
      step(); start = 1'b0;
      edge_n++;
      if (busy) nbusy++;
      if (done) got_done = 1'b1;
    end
    chk("mul done edge", edge_n, 9);
    chk("mul busy cycles", nbusy, 8);
    chk("mul acc", acc, 8'h01);
    chk("mul ext", ext, 8'hFE);
    chk("mul flags", flags, 5'h02);

    // 16-bit DIV then divide by zero
    w_din = 16'd1000; w_acc_we = 1'b1; step(); w_acc_we = 1'b0;
    w_din = 16'd7; w_tmp_we = 1'b1; step(); w_tmp_we = 1'b0;
    w_op = 5'd19; w_start = 1'b1; step(); w_start = 1'b0;
    edge_n = 1;
    while (!w_done && edge_n < 40) begin step(); edge_n++; end
    chk("div16 done edge", edge_n, 17);
    chk("div16 quotient", w_acc, 16'd142);
    chk("div16 remainder", w_ext, 16'd6);
    chk("div16 Z,C", w_flags[1:0], 2'b00);
    chk("div16 dbz", w_dbz, 0);
    w_din = 16'd0; w_tmp_we = 1'b1; step(); w_tmp_we = 1'b0;
    w_op = 5'd19; w_start = 1'b1; step(); w_start = 1'b0;
    chk("div0 busy", w_busy, 0);
    chk("div0 done", w_done, 1);
    chk("div0 dbz", w_dbz, 1);
    chk("div0 acc", w_acc, 16'd142);
    chk("div0 ext", w_ext, 16'd6);
    chk("div0 C", w_flags[1], 1);
    step();
    chk("div0 dbz sticky", w_dbz, 1);
    chk("div0 done drop", w_done, 0);
    w_op = 5'd31; w_start = 1'b1; step(); w_start = 1'b0;
    chk("dbz cleared by start", w_dbz, 0);

    // Reset in the middle of a MUL
    load8(8'hFF, 8'hFF, 5'h1F);
    op = 5'd18; start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst acc", acc, 0);
    chk("midrst ext", ext, 0);
    chk("midrst flags", flags, 0);
    chk("midrst done", done, 0);
    step();
    rst = 1'b0;
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    chk("midrst no done", saw_done, 0);
    chk("midrst no busy", saw_busy, 0);
    chk("midrst acc hold", acc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
